// File: rtl/aclint_memory_pkg.sv
// Shared EEI constants for the membus and the ACLINT register window,
// plus register decode and byte-strobe merge helpers.
package eei;

  localparam int XLEN              = 64;
  localparam int MEMBUS_DATA_WIDTH = 64;
  localparam int MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH / 8;

  localparam logic [XLEN-1:0] MMAP_ACLINT_BEGIN = 64'h0000_0000_0200_0000;
  localparam logic [XLEN-1:0] MMAP_ACLINT_END   = 64'h0000_0000_020b_ffff;

  // Word offsets inside the ACLINT window
  localparam logic [15:0] MMAP_ACLINT_MSIP     = 16'h0000;
  localparam logic [15:0] MMAP_ACLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] MMAP_ACLINT_MTIME    = 16'h7ff8;
  localparam logic [15:0] MMAP_ACLINT_SETSSIP  = 16'h8000;

  // mtimecmp powers up at the maximum so no timer interrupt is pending
  localparam logic [63:0] ACLINT_MTIMECMP_RESET = '1;

  typedef enum logic [2:0] {
    ACLINT_REG_MSIP,
    ACLINT_REG_MTIMECMP,
    ACLINT_REG_MTIME,
    ACLINT_REG_SETSSIP,
    ACLINT_REG_NONE
  } aclint_reg_e;

  // Address bits [2:0] are ignored: every access targets an aligned 64-bit word
  function automatic aclint_reg_e aclint_decode(input logic [15:0] off);
    logic [15:0] word_off;
    word_off = {off[15:3], 3'b000};
    case (word_off)
      MMAP_ACLINT_MSIP:     return ACLINT_REG_MSIP;
      MMAP_ACLINT_MTIMECMP: return ACLINT_REG_MTIMECMP;
      MMAP_ACLINT_MTIME:    return ACLINT_REG_MTIME;
      MMAP_ACLINT_SETSSIP:  return ACLINT_REG_SETSSIP;
      default:              return ACLINT_REG_NONE;
    endcase
  endfunction

  // Replace the bytes of old_val selected by wmask with the bytes of wdata
  function automatic logic [MEMBUS_DATA_WIDTH-1:0] apply_wmask(
    input logic [MEMBUS_DATA_WIDTH-1:0] old_val,
    input logic [MEMBUS_DATA_WIDTH-1:0] wdata,
    input logic [MEMBUS_MASK_WIDTH-1:0] wmask
  );
    logic [MEMBUS_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int unsigned i = 0; i < MEMBUS_MASK_WIDTH; i++) begin
      if (wmask[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aclint_memory_if.sv
// Membus request/response bundle between the CPU (master) and a responder (slave).
interface aclint_memory_if;
  import eei::*;

  logic                         valid;
  logic                         ready;
  logic [XLEN-1:0]              addr;
  logic                         wen;
  logic [MEMBUS_DATA_WIDTH-1:0] wdata;
  logic [MEMBUS_MASK_WIDTH-1:0] wmask;
  logic                         rvalid;
  logic [MEMBUS_DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/aclint_memory_mtime_counter.sv
// Free-running 64-bit mtime with a prescaler and a byte-masked load port.
module aclint_mtime_counter
  import eei::*;
#(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_en,
  input  logic [MEMBUS_DATA_WIDTH-1:0] load_data,
  input  logic [MEMBUS_MASK_WIDTH-1:0] load_mask,
  output logic [63:0]                  mtime
);

  localparam int unsigned PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MTIME_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          tick;

  // Next prescaler/mtime: written bytes override the incremented value,
  // unwritten bytes keep the increment (including any carry into them)
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = mtime_q + {63'b0, tick};
    if (load_en) begin
      presc_d = '0;
      mtime_d = apply_wmask(mtime_d, load_data, load_mask);
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime = mtime_q;

endmodule

// File: rtl/aclint_memory.sv
// ACLINT responder on the membus: MSWI, MTIMER and SSWI registers for one hart.
module aclint_memory
  import eei::*;
#(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  aclint_memory_if.slave        membus,
  output logic                  aclint_msip,
  output logic                  aclint_mtip,
  output logic                  aclint_ssip_set,
  output logic [63:0]           aclint_mtime
);

  logic [15:0]                  off;
  aclint_reg_e                  reg_sel;
  logic                         wr;
  logic [MEMBUS_DATA_WIDTH-1:0] rd_word;
  logic                         mtime_load;
  logic [63:0]                  mtime;

  logic                         msip_q, msip_d;
  logic [63:0]                  mtimecmp_q, mtimecmp_d;
  logic                         rvalid_q, rvalid_d;
  logic [MEMBUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                         ssip_q, ssip_d;

  aclint_mtime_counter #(
    .MTIME_DIV (MTIME_DIV)
  ) u_mtime (
    .clk       (clk),
    .rst       (rst),
    .load_en   (mtime_load),
    .load_data (membus.wdata),
    .load_mask (membus.wmask),
    .mtime     (mtime)
  );

  // Decode and read mux on the registered (pre-write) register values
  always_comb begin
    off        = 16'(membus.addr - MMAP_ACLINT_BEGIN);
    reg_sel    = aclint_decode(off);
    wr         = membus.valid && membus.wen;
    mtime_load = wr && (reg_sel == ACLINT_REG_MTIME);
    rd_word    = '0;
    case (reg_sel)
      ACLINT_REG_MSIP:     rd_word = {63'b0, msip_q};
      ACLINT_REG_MTIMECMP: rd_word = mtimecmp_q;
      ACLINT_REG_MTIME:    rd_word = mtime;
      default:             rd_word = '0;
    endcase
  end

  // Register writes, SETSSIP pulse and one-cycle response
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    ssip_d     = 1'b0;
    rvalid_d   = membus.valid;
    rdata_d    = membus.valid ? rd_word : '0;
    if (wr) begin
      case (reg_sel)
        ACLINT_REG_MSIP:     if (membus.wmask[0]) msip_d = membus.wdata[0];
        ACLINT_REG_MTIMECMP: mtimecmp_d = apply_wmask(mtimecmp_q, membus.wdata, membus.wmask);
        ACLINT_REG_SETSSIP:  ssip_d = membus.wmask[0] && membus.wdata[0];
        default:             ;
      endcase
    end
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= ACLINT_MTIMECMP_RESET;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      ssip_q     <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ssip_q     <= ssip_d;
    end
  end

  assign membus.ready    = 1'b1;
  assign membus.rvalid   = rvalid_q;
  assign membus.rdata    = rdata_q;
  assign aclint_msip     = msip_q;
  assign aclint_mtip     = (mtime >= mtimecmp_q);
  assign aclint_ssip_set = ssip_q;
  assign aclint_mtime    = mtime;

endmodule

// File: tb/tb_aclint_memory.sv
// Directed bench for aclint_memory: vector table plus timing sequences.
module tb_aclint_memory;
  import eei::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        msip, mtip, ssip;
  logic [63:0] mtime;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  aclint_memory_if bus_if ();

  aclint_memory #(
    .MTIME_DIV (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .membus          (bus_if.slave),
    .aclint_msip     (msip),
    .aclint_mtip     (mtip),
    .aclint_ssip_set (ssip),
    .aclint_mtime    (mtime)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [15:0] off;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Called at a negedge; returns at the negedge after acceptance (response cycle)
  task automatic bus(input logic wen, input logic [15:0] off,
                     input logic [63:0] wd, input logic [7:0] wm);
    bus_if.valid = 1'b1;
    bus_if.wen   = wen;
    bus_if.addr  = MMAP_ACLINT_BEGIN + {48'b0, off};
    bus_if.wdata = wd;
    bus_if.wmask = wm;
    @(negedge clk);
    bus_if.valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned pulses;

    vecs[0]  = '{1'b1, 16'h0000, 64'h1,                   8'hff, 64'h0};
    vecs[1]  = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h1};
    vecs[2]  = '{1'b1, 16'h0000, 64'hffff_ffff_ffff_fffe, 8'hff, 64'h1};
    vecs[3]  = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h0};
    vecs[4]  = '{1'b1, 16'h0000, 64'h1,                   8'hf0, 64'h0};
    vecs[5]  = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h0};
    vecs[6]  = '{1'b1, 16'h0003, 64'h1,                   8'h01, 64'h0};
    vecs[7]  = '{1'b0, 16'h0006, 64'h0,                   8'h00, 64'h1};
    vecs[8]  = '{1'b1, 16'h0000, 64'h0,                   8'h01, 64'h1};
    vecs[9]  = '{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'hff, 64'hffff_ffff_ffff_ffff};
    vecs[10] = '{1'b0, 16'h4000, 64'h0,                   8'h00, 64'h1122_3344_5566_7788};
    vecs[11] = '{1'b1, 16'h4000, 64'h0000_0000_aabb_ccdd, 8'h0f, 64'h1122_3344_5566_7788};
    vecs[12] = '{1'b0, 16'h4000, 64'h0,                   8'h00, 64'h1122_3344_aabb_ccdd};
    vecs[13] = '{1'b1, 16'h4000, 64'h9999_9999_0000_0000, 8'hf0, 64'h1122_3344_aabb_ccdd};
    vecs[14] = '{1'b0, 16'h4000, 64'h0,                   8'h00, 64'h9999_9999_aabb_ccdd};
    vecs[15] = '{1'b1, 16'h4000, 64'hffff_ffff_ffff_ffff, 8'hff, 64'h9999_9999_aabb_ccdd};
    vecs[16] = '{1'b0, 16'h8000, 64'h0,                   8'h00, 64'h0};
    vecs[17] = '{1'b0, 16'h0100, 64'h0,                   8'h00, 64'h0};
    vecs[18] = '{1'b1, 16'h0100, 64'hffff_ffff_ffff_ffff, 8'hff, 64'h0};
    vecs[19] = '{1'b0, 16'h0100, 64'h0,                   8'h00, 64'h0};

    bus_if.valid = 1'b0;
    bus_if.wen   = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    bus_if.wmask = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_mtime",  mtime, 64'h0);
    chk("reset_mtip",   {63'b0, mtip}, 64'h0);
    chk("reset_msip",   {63'b0, msip}, 64'h0);
    chk("reset_ssip",   {63'b0, ssip}, 64'h0);
    chk("reset_rvalid", {63'b0, bus_if.rvalid}, 64'h0);
    chk("reset_rdata",  bus_if.rdata, 64'h0);
    chk("ready_high",   {63'b0, bus_if.ready}, 64'h1);
    rst = 1'b0;

    // mtime counts one per cycle from reset release; load returns pre-edge value
    repeat (4) @(negedge clk);
    bus(1'b0, MMAP_ACLINT_MTIME, 64'h0, 8'h00);
    chk("mtime_ld_rvalid", {63'b0, bus_if.rvalid}, 64'h1);
    chk("mtime_ld_rdata",  bus_if.rdata, 64'd4);
    chk("mtime_after_ld",  mtime, 64'd5);

    // Register table
    for (int i = 0; i < 20; i++) begin
      bus(vecs[i].wen, vecs[i].off, vecs[i].wdata, vecs[i].wmask);
      chk($sformatf("vec%0d_rvalid", i), {63'b0, bus_if.rvalid}, 64'h1);
      chk($sformatf("vec%0d_rdata", i), bus_if.rdata, vecs[i].exp_rdata);
    end
    @(negedge clk);
    chk("idle_rvalid", {63'b0, bus_if.rvalid}, 64'h0);

    // MSIP output timing
    bus(1'b1, MMAP_ACLINT_MSIP, 64'h1, 8'h01);
    chk("msip_set", {63'b0, msip}, 64'h1);
    bus(1'b0, MMAP_ACLINT_MSIP, 64'h0, 8'h00);
    chk("msip_ld", bus_if.rdata, 64'h1);
    bus(1'b1, MMAP_ACLINT_MSIP, 64'h0, 8'h01);
    chk("msip_clr", {63'b0, msip}, 64'h0);

    // SETSSIP: one pulse for a 1 write, none for 0 or for a write without strobe 0
    bus(1'b1, MMAP_ACLINT_SETSSIP, 64'h1, 8'h01);
    chk("ssip_pulse", {63'b0, ssip}, 64'h1);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (ssip) pulses++;
    end
    chk("ssip_single", 64'(pulses), 64'd0);
    pulses = 0;
    bus(1'b1, MMAP_ACLINT_SETSSIP, 64'h0, 8'hff);
    if (ssip) pulses++;
    bus(1'b1, MMAP_ACLINT_SETSSIP, 64'h1, 8'hfe);
    if (ssip) pulses++;
    repeat (3) begin
      @(negedge clk);
      if (ssip) pulses++;
    end
    chk("ssip_no_pulse", 64'(pulses), 64'd0);

    // Timer compare: mtime=90 then mtimecmp=100 back-to-back
    bus(1'b1, MMAP_ACLINT_MTIME, 64'd90, 8'hff);
    chk("mtime_set", mtime, 64'd90);
    bus(1'b1, MMAP_ACLINT_MTIMECMP, 64'd100, 8'hff);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("mtip_mtime_k%0d", k), mtime, 64'(90 + k));
      chk($sformatf("mtip_k%0d", k), {63'b0, mtip}, (90 + k >= 100) ? 64'h1 : 64'h0);
    end
    bus(1'b1, MMAP_ACLINT_MTIMECMP, 64'hffff_ffff_ffff_ffff, 8'hff);
    chk("mtip_drop", {63'b0, mtip}, 64'h0);

    // Store low word of mtime while it increments: carry lands in the high word
    bus(1'b1, MMAP_ACLINT_MTIME, 64'h0000_0005_ffff_ffff, 8'hff);
    bus(1'b1, MMAP_ACLINT_MTIME, 64'h0000_0001_0000_0000, 8'h0f);
    chk("mtime_race_rdata", bus_if.rdata, 64'h0000_0005_ffff_ffff);
    chk("mtime_race_val",   mtime, 64'h0000_0006_0000_0000);
    @(negedge clk);
    chk("mtime_race_next",  mtime, 64'h0000_0006_0000_0001);

    // Back-to-back load/store/load
    bus(1'b0, MMAP_ACLINT_MSIP, 64'h0, 8'h00);
    chk("b2b_rv0", {63'b0, bus_if.rvalid}, 64'h1);
    bus(1'b1, MMAP_ACLINT_MSIP, 64'h1, 8'h01);
    chk("b2b_rv1", {63'b0, bus_if.rvalid}, 64'h1);
    chk("b2b_rd1", bus_if.rdata, 64'h0);
    bus(1'b0, MMAP_ACLINT_MSIP, 64'h0, 8'h00);
    chk("b2b_rv2", {63'b0, bus_if.rvalid}, 64'h1);
    chk("b2b_rd2", bus_if.rdata, 64'h1);
    @(negedge clk);
    chk("b2b_rv3", {63'b0, bus_if.rvalid}, 64'h0);

    // Reset on the acceptance edge: no response, store dropped
    bus_if.valid = 1'b1;
    bus_if.wen   = 1'b1;
    bus_if.addr  = MMAP_ACLINT_BEGIN + 64'h8000;
    bus_if.wdata = 64'h1;
    bus_if.wmask = 8'h01;
    rst = 1'b1;
    @(negedge clk);
    bus_if.valid = 1'b0;
    rst = 1'b0;
    chk("rstmid_rvalid", {63'b0, bus_if.rvalid}, 64'h0);
    chk("rstmid_ssip",   {63'b0, ssip}, 64'h0);
    chk("rstmid_msip",   {63'b0, msip}, 64'h0);
    chk("rstmid_mtime",  mtime, 64'h0);
    @(negedge clk);
    chk("rstmid_rvalid2", {63'b0, bus_if.rvalid}, 64'h0);
    chk("rstmid_ssip2",   {63'b0, ssip}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
